// File: rtl/ws2812_tx.sv
// ws2812_tx: serialises 24-bit GRB pixels MSB-first onto the single-wire WS2812 data line.
// Latency: dout rises the cycle after the accepting edge; a pixel lasts 24*BIT_CYC cycles, frame end adds RESET_CYC.
// Backpressure: pixel_ready only in IDLE or on the final cycle of a non-last pixel; pixel_valid may be held.
module ws2812_tx #(
   parameter int T0H_CYC   = 20,
   parameter int T1H_CYC   = 40,
   parameter int BIT_CYC   = 63,
   parameter int RESET_CYC = 3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] pixel_data,
   input  logic        pixel_valid,
   input  logic        pixel_last,
   output logic        pixel_ready,
   output logic        dout,
   output logic        busy,
   output logic        frame_done
);

   localparam int CNT_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] BIT_END   = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] LATCH_END = CW'(RESET_CYC - 1);
   localparam logic [CW-1:0] T0H_LIM   = CW'(T0H_CYC);
   localparam logic [CW-1:0] T1H_LIM   = CW'(T1H_CYC);

   // Refuse to elaborate with timing that cannot produce distinguishable 0/1 pulses.
   generate
      if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && RESET_CYC >= 1)) begin : g_param_check
         $fatal(1, "ws2812_tx: need 0 < T0H_CYC < T1H_CYC < BIT_CYC and RESET_CYC >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_LATCH} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cyc, cyc_nx;
   logic [4:0]    bit_idx, bit_nx;
   logic [23:0]   shift, shift_nx;
   logic          last_q, last_nx;
   logic          dout_nx, ready_nx, busy_nx, done_nx;
   logic          xfer;

   assign xfer = pixel_valid & pixel_ready;

   // State and output registers; reset abandons any pixel in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cyc         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         last_q      <= 1'b0;
         dout        <= 1'b0;
         pixel_ready <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state       <= state_nx;
         cyc         <= cyc_nx;
         bit_idx     <= bit_nx;
         shift       <= shift_nx;
         last_q      <= last_nx;
         dout        <= dout_nx;
         pixel_ready <= ready_nx;
         busy        <= busy_nx;
         frame_done  <= done_nx;
      end
   end

   // Next-state: bit timing, shifting, zero-gap reload, latch countdown.
   always_comb begin
      state_nx = state;
      cyc_nx   = cyc;
      bit_nx   = bit_idx;
      shift_nx = shift;
      last_nx  = last_q;
      case (state)
         ST_IDLE: begin
            if (xfer) begin
               state_nx = ST_SEND;
               cyc_nx   = '0;
               bit_nx   = 5'd23;
               shift_nx = pixel_data;
               last_nx  = pixel_last;
            end
         end
         ST_SEND: begin
            if (cyc == BIT_END) begin
               cyc_nx = '0;
               if (bit_idx != 5'd0) begin
                  shift_nx = {shift[22:0], 1'b0};
                  bit_nx   = bit_idx - 5'd1;
               end else if (last_q) begin
                  state_nx = ST_LATCH;
               end else if (xfer) begin
                  bit_nx   = 5'd23;
                  shift_nx = pixel_data;
                  last_nx  = pixel_last;
               end else begin
                  state_nx = ST_IDLE;
               end
            end else begin
               cyc_nx = cyc + CW'(1);
            end
         end
         ST_LATCH: begin
            if (cyc == LATCH_END) begin
               state_nx = ST_IDLE;
               cyc_nx   = '0;
            end else begin
               cyc_nx = cyc + CW'(1);
            end
         end
         default: begin
            state_nx = ST_IDLE;
            cyc_nx   = '0;
         end
      endcase
   end

   // Outputs derived from the next state so the registered pins line up with it.
   always_comb begin
      dout_nx  = (state_nx == ST_SEND) &&
                 (cyc_nx < (shift_nx[23] ? T1H_LIM : T0H_LIM));
      ready_nx = (state_nx == ST_IDLE) ||
                 ((state_nx == ST_SEND) && (cyc_nx == BIT_END) &&
                  (bit_nx == 5'd0) && !last_nx);
      busy_nx  = (state_nx != ST_IDLE);
      done_nx  = (state == ST_LATCH) && (state_nx == ST_IDLE);
   end

endmodule
